reg_xfer_ctrl: RTL

Multi-cycle register-transfer controller for the single-bus datapath. It accepts one 8-bit instruction per handshake and sequences the register bank's `reg_no` / `ld_reg` / `t_reg` controls, plus the temp (A) register, result (Z) register and ALU opcode, across several clock cycles. It sits directly upstream of the register bank and drives every control line that bank consumes. At most one bus driver is active in any cycle.

---
 rtl/rxc_pkg.sv | 30 +++
 rtl/reg_xfer_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rxc_pkg.sv
// Shared definitions for the register-transfer controller: states, opcodes, field positions.
package rxc_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned REG_W = 3;

  localparam int unsigned OP_HI = 7;
  localparam int unsigned OP_LO = 6;
  localparam int unsigned RD_HI = 5;
  localparam int unsigned RD_LO = 3;
  localparam int unsigned RS_HI = 2;
  localparam int unsigned RS_LO = 0;

  localparam logic [OP_W-1:0] OP_MOV  = 2'b00;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b10;
  localparam logic [OP_W-1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    RD_A   = 3'd3,
    RD_B   = 3'd4,
    WB_ALU = 3'd5,
    WB_MOV = 3'd6,
    HALT   = 3'd7
  } state_e;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Multi-cycle controller sequencing register-bank, temp (A), Z and ALU controls per instruction.
module reg_xfer_ctrl
  import rxc_pkg::*;
#(
  parameter int unsigned IW = 8,
  parameter int unsigned CW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [REG_W-1:0] reg_no,
  output logic             ld_reg,
  output logic             t_reg,
  output logic             ld_tmp,
  output logic             t_tmp,
  output logic             ld_z,
  output logic             t_z,
  output logic             alu_op,
  output logic             busy,
  output logic             halted,
  output logic [CW-1:0]    retired
);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [CW-1:0]   retired_q, retired_d;

  logic [OP_W-1:0]  ir_op;
  logic [REG_W-1:0] ir_rd;
  logic [REG_W-1:0] ir_rs;

  assign ir_op = ir_q[OP_HI:OP_LO];
  assign ir_rd = ir_q[RD_HI:RD_LO];
  assign ir_rs = ir_q[RS_HI:RS_LO];

  assign retired = retired_q;

  // State, instruction and retired-count registers; reset wins over any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, instruction capture on handshake, and retire count on write-back.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = (ir_op == OP_HALT) ? HALT : RD_A;
      RD_A:   state_d = (ir_op == OP_MOV) ? WB_MOV : RD_B;
      RD_B:   state_d = WB_ALU;
      WB_ALU, WB_MOV: begin
        state_d   = FETCH;
        retired_d = retired_q + CW'(1);
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: at most one of t_reg / t_tmp / t_z per state.
  always_comb begin
    instr_ready = 1'b0;
    reg_no      = '0;
    ld_reg      = 1'b0;
    t_reg       = 1'b0;
    ld_tmp      = 1'b0;
    t_tmp       = 1'b0;
    ld_z        = 1'b0;
    t_z         = 1'b0;
    alu_op      = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      IDLE: ;
      FETCH: instr_ready = 1'b1;
      DECODE: busy = 1'b1;
      RD_A: begin
        busy   = 1'b1;
        reg_no = ir_rs;
        t_reg  = 1'b1;
        ld_tmp = 1'b1;
      end
      RD_B: begin
        busy   = 1'b1;
        reg_no = ir_rd;
        t_reg  = 1'b1;
        ld_z   = 1'b1;
        alu_op = ir_op[1];
      end
      WB_ALU: begin
        busy   = 1'b1;
        reg_no = ir_rd;
        t_z    = 1'b1;
        ld_reg = 1'b1;
      end
      WB_MOV: begin
        busy   = 1'b1;
        reg_no = ir_rd;
        t_tmp  = 1'b1;
        ld_reg = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
